md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 159 +++++++++++++++
 tb/tb_md_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit holding the HI/LO registers: fixed-latency mult/multu (5 cycles),
// div/divu (10 cycles, only when MDU_DIV_EN is defined), and single-cycle mthi/mtlo.
module md_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
`ifdef MDU_DIV_EN
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
`endif
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1
`ifdef MDU_DIV_EN
    ,
    StDiv  = 2'd2
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
  logic [63:0] prod;
  assign prod = $signed({{32{sgn_q & op_a_q[31]}}, op_a_q}) *
                $signed({{32{sgn_q & op_b_q[31]}}, op_b_q});

`ifdef MDU_DIV_EN
  // Divide magnitudes unsigned, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
  logic [31:0] abs_a, abs_b, uquo, urem, quo, rem;
  logic        neg_quo, neg_rem;

  always_comb begin
    abs_a   = (sgn_q & op_a_q[31]) ? -op_a_q : op_a_q;
    abs_b   = (sgn_q & op_b_q[31]) ? -op_b_q : op_b_q;
    neg_quo = sgn_q & (op_a_q[31] ^ op_b_q[31]);
    neg_rem = sgn_q & op_a_q[31];
    uquo    = (abs_b != 32'd0) ? abs_a / abs_b : 32'd0;
    urem    = (abs_b != 32'd0) ? abs_a % abs_b : 32'd0;
    quo     = neg_quo ? -uquo : uquo;
    rem     = neg_rem ? -urem : urem;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (mdop)
            OpMult, OpMultu: begin
              op_a_d  = a;
              op_b_d  = b;
              sgn_d   = ~mdop[0];
              cnt_d   = 4'd5;
              state_d = StMul;
            end
`ifdef MDU_DIV_EN
            OpDiv, OpDivu: begin
              op_a_d  = a;
              op_b_d  = b;
              sgn_d   = ~mdop[0];
              cnt_d   = 4'd10;
              state_d = StDiv;
            end
`endif
            OpMthi:  hi_d = a;
            OpMtlo:  lo_d = a;
            default: ;
          endcase
        end
      end

      StMul: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

`ifdef MDU_DIV_EN
      StDiv: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          // Divide by zero still runs the full period but leaves HI/LO alone.
          if (op_b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_a_q  <= 32'd0;
      op_b_q  <= 32'd0;
      sgn_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit with a HI/LO scoreboard; divider checks depend on MDU_DIV_EN.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur_hilo;

  md_unit dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .mdop (mdop),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mul_model(input logic [2:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
    logic signed [63:0] sx, sy;
    if (op == 3'd0) begin
      sx = $signed({{32{x[31]}}, x});
      sy = $signed({{32{y[31]}}, y});
      return sx * sy;
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // Drive one start cycle; returns at the next negedge with start low and operands scrambled.
  task automatic kick(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    mdop  = op;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp_hilo);
    exp_q.push_back(exp_hilo);
    kick(op, x, y);
  endtask

  // Count remaining busy cycles, then score HI/LO and the done pulse.
  task automatic finish(input string tag, input int exp_cycles);
    int n  = 0;
    int dn = 0;
    logic [63:0] e;
    while (busy && n < 40) begin
      n++;
      if (done) dn++;
      @(negedge clk);
    end
    checks++;
    if (n != exp_cycles) begin
      errors++;
      $error("FAIL %s_busy_len observed=%0d expected=%0d", tag, n, exp_cycles);
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $error("FAIL %s_done_early observed=%0d expected=0", tag, dn);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $error("FAIL %s_done observed=%0b expected=1", tag, done);
    end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin
      errors++;
      $error("FAIL %s_hilo observed=%0h expected=%0h", tag, {hi, lo}, e);
    end
    cur_hilo = e;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $error("FAIL %s_done_clear observed=%0b expected=0", tag, done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] x, y;
    logic [2:0]  op;

    reset = 1'b1;
    start = 1'b0;
    mdop  = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    cur_hilo = 64'd0;

    // mthi / mtlo: single edge, no busy, no done
    kick(3'd4, 32'h1234_5678, 32'h0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", busy, 1'b0);
    chk("mthi_done", done, 1'b0);
    kick(3'd5, 32'hCAFE_F00D, 32'h0);
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);
    chk("mtlo_busy", busy, 1'b0);
    cur_hilo = {32'h1234_5678, 32'hCAFE_F00D};

    // mdop 110/111 are no-ops
    kick(3'd6, 32'h1111_1111, 32'h2);
    chk("nop6_busy", busy, 1'b0);
    chk("nop6_hilo", {hi, lo}, cur_hilo);
    kick(3'd7, 32'h2222_2222, 32'h3);
    chk("nop7_busy", busy, 1'b0);
    chk("nop7_hilo", {hi, lo}, cur_hilo);

    launch(3'd0, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    finish("mult_m2x3", 5);
    launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    finish("multu_max", 5);
    launch(3'd0, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000});
    finish("mult_minsq", 5);

    // Starts while busy (mult and mthi) must be ignored
    launch(3'd0, 32'd5, 32'd7, {32'h0, 32'd35});
    start = 1'b1;
    mdop  = 3'd0;
    a     = 32'd3;
    b     = 32'd3;
    @(negedge clk);
    mdop  = 3'd4;
    a     = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    finish("mult_ignore", 3);

    for (int i = 0; i < 4; i++) begin
      x  = $urandom;
      y  = $urandom;
      op = 3'($urandom_range(0, 1));
      launch(op, x, y, mul_model(op, x, y));
      finish("mult_rand", 5);
    end

`ifdef MDU_DIV_EN
    launch(3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    finish("div_m7d2", 10);
    launch(3'd2, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
    finish("div_7dm2", 10);
    launch(3'd3, 32'd100, 32'd7, {32'd2, 32'd14});
    finish("divu_100d7", 10);
    launch(3'd3, 32'd7, 32'd0, cur_hilo);
    finish("divu_by0", 10);
    launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    finish("div_ovf", 10);

    // Reset on the 4th busy cycle of a div abandons it
    kick(3'd2, 32'd1000, 32'd3);
    chk("divrst_busy1", busy, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("divrst_busy", busy, 1'b0);
    chk("divrst_hilo", {hi, lo}, 64'd0);
    chk("divrst_done", done, 1'b0);
    cur_hilo = 64'd0;
`else
    // Without the divider, div/divu do nothing
    kick(3'd2, 32'd10, 32'd2);
    for (int i = 0; i < 12; i++) begin
      chk("nodiv_busy", busy, 1'b0);
      chk("nodiv_done", done, 1'b0);
      @(negedge clk);
    end
    chk("nodiv_hilo", {hi, lo}, cur_hilo);
    kick(3'd3, 32'd10, 32'd2);
    chk("nodivu_busy", busy, 1'b0);
    chk("nodivu_hilo", {hi, lo}, cur_hilo);
`endif

    // Reset mid-mult abandons it without writing HI/LO from the product
    launch(3'd0, 32'd9, 32'd9, {32'h0, 32'd81});
    finish("mult_pre_rst", 5);
    kick(3'd1, 32'd6, 32'd6);
    chk("mulrst_busy1", busy, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mulrst_busy", busy, 1'b0);
    chk("mulrst_hilo", {hi, lo}, 64'd0);
    chk("mulrst_done", done, 1'b0);
    repeat (6) @(negedge clk);
    chk("mulrst_stay", {hi, lo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
